sr_flag_arbiter: RTL and testbench

Shared-flag controller that owns a bank of NFLAG set/reset flags and arbitrates set/clear commands from NREQ requesters onto it, one command per clock. Each flag behaves as a clocked SR element (set, clear, hold; simultaneous set+clear holds). The block sits between the requesting agents and any logic that consumes the flag vector, and supports a lock so one requester can issue an atomic sequence of flag updates.

---
 rtl/sr_flag_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_sr_flag_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sr_flag_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sr_flag_arbiter
//  Description : Owns a bank of NFLAG clocked SR flags and arbitrates
//                set/clear commands from NREQ requesters onto it, one
//                command per clock, with a lock that lets one requester
//                issue an atomic sequence of updates.
//                Build option SR_ARB_RR_EN selects round-robin arbitration;
//                without it the lowest requester index wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module sr_flag_arbiter #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IW    = $clog2(NFLAG),  // derived, leave at default
  parameter int RW    = $clog2(NREQ)    // derived, leave at default
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    s,
  input  logic [NREQ-1:0]    r,
  input  logic [NREQ*IW-1:0] idx,
  input  logic [NREQ-1:0]    lock,
  output logic [NREQ-1:0]    gnt,
  output logic [NFLAG-1:0]   q,
  output logic               locked,
  output logic [RW-1:0]      owner,
  output logic               err
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NFLAG-1:0] flags_q, flags_d;
  logic [RW-1:0]    owner_q, owner_d;
  logic             err_q, err_d;

  logic [NREQ-1:0]  cand;
  logic             win_vld;
  logic [RW-1:0]    win_id;
  logic [IW-1:0]    win_idx;
  logic             win_s;
  logic             win_r;
  logic             win_lock;
  logic             win_oor;

`ifdef SR_ARB_RR_EN
  logic [RW-1:0]    ptr_q, ptr_d;
`endif

  // Candidate set: everyone in IDLE, only the lock owner while LOCKED.
  always_comb begin
    cand = req;
    if (state_q == ST_LOCKED) begin
      cand          = '0;
      cand[owner_q] = req[owner_q];
    end
  end

`ifdef SR_ARB_RR_EN
  // Round-robin pick: first candidate at or above the pointer, wrapping.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!win_vld && cand[j]) begin
        win_vld = 1'b1;
        win_id  = RW'(j);
      end
    end
  end
`else
  // Fixed priority pick: lowest candidate index wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_vld = 1'b1;
        win_id  = RW'(i);
      end
    end
  end
`endif

  // Fields of the winning requester's command.
  always_comb begin
    win_idx  = idx[int'(win_id)*IW +: IW];
    win_s    = s[win_id];
    win_r    = r[win_id];
    win_lock = lock[win_id];
    win_oor  = (int'(win_idx) >= NFLAG);
  end

  // Next-state: grant pulse, flag update, error capture, lock FSM, pointer.
  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    flags_d = flags_q;
    owner_d = owner_q;
    err_d   = err_q;
`ifdef SR_ARB_RR_EN
    ptr_d   = ptr_q;
`endif

    if (win_vld) begin
      gnt_d[win_id] = 1'b1;
      if (win_oor) begin
        err_d = 1'b1;
      end else begin
        // SR behaviour: set, clear, or hold on s=r (both 0 or both 1).
        for (int f = 0; f < NFLAG; f++) begin
          if (win_idx == IW'(f)) begin
            if (win_s && !win_r)      flags_d[f] = 1'b1;
            else if (!win_s && win_r) flags_d[f] = 1'b0;
          end
        end
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (win_vld && win_lock) begin
          state_d = ST_LOCKED;
          owner_d = win_id;
        end
      end
      ST_LOCKED: begin
        // Owner releasing the lock; any command it presents this edge has
        // already been granted above.
        if (!lock[owner_q]) begin
          state_d = ST_IDLE;
          owner_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = '0;
      end
    endcase

`ifdef SR_ARB_RR_EN
    // Pointer frozen for grants inside a held lock; advances otherwise,
    // including on the grant that releases the lock.
    if (win_vld && ((state_q == ST_IDLE) || !lock[owner_q])) begin
      ptr_d = (int'(win_id) == NREQ - 1) ? '0 : win_id + 1'b1;
    end
`endif
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      flags_q <= '0;
      owner_q <= '0;
      err_q   <= 1'b0;
`ifdef SR_ARB_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      flags_q <= flags_d;
      owner_q <= owner_d;
      err_q   <= err_d;
`ifdef SR_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign gnt    = gnt_q;
  assign q      = flags_q;
  assign locked = (state_q == ST_LOCKED);
  assign owner  = owner_q;
  assign err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_flag_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sr_flag_arbiter
//  Description : Directed self-checking bench for sr_flag_arbiter. A second
//                instance with NFLAG=6 exercises out-of-range indices.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_flag_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [3:0]  req = '0, s = '0, r = '0, lock = '0;
  logic [11:0] idx = '0;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic        locked;
  logic [1:0]  owner;
  logic        err;

  logic [3:0]  req6 = '0, s6 = '0, r6 = '0, lock6 = '0;
  logic [11:0] idx6 = '0;
  logic [3:0]  gnt6;
  logic [5:0]  q6;
  logic        locked6;
  logic [1:0]  owner6;
  logic        err6;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] q_exp;
  logic [3:0] g_exp;

  sr_flag_arbiter #(.NREQ(4), .NFLAG(8)) dut (
    .clk(clk), .rst(rst), .req(req), .s(s), .r(r), .idx(idx), .lock(lock),
    .gnt(gnt), .q(q), .locked(locked), .owner(owner), .err(err)
  );

  sr_flag_arbiter #(.NREQ(4), .NFLAG(6)) dut6 (
    .clk(clk), .rst(rst), .req(req6), .s(s6), .r(r6), .idx(idx6), .lock(lock6),
    .gnt(gnt6), .q(q6), .locked(locked6), .owner(owner6), .err(err6)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_q", q, 8'h00);
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_locked", locked, 1'b0);
    chk("rst_owner", owner, 2'd0);
    chk("rst_err", err, 1'b0);

    // Single set / clear / hold from requester 2 on flag 5
    req = 4'b0100; s = 4'b0100; idx[8:6] = 3'd5;
    tick();
    chk("set_gnt", gnt, 4'b0100);
    chk("set_q", q, 8'h20);
    s = 4'b0000; r = 4'b0100;
    tick();
    chk("clr_gnt", gnt, 4'b0100);
    chk("clr_q", q, 8'h00);
    s = 4'b0100; r = 4'b0000;
    tick();
    chk("set2_q", q, 8'h20);
    s = 4'b0100; r = 4'b0100;
    tick();
    chk("sr11_gnt", gnt, 4'b0100);
    chk("sr11_q", q, 8'h20);
    s = 4'b0000; r = 4'b0000;
    tick();
    chk("sr00_gnt", gnt, 4'b0100);
    chk("sr00_q", q, 8'h20);
    req = 4'b0000;
    tick();
    chk("idle_gnt", gnt, 4'b0000);
    q_exp = 8'h20;

    // No-op command from requester 3 (leaves RR pointer at 0)
    req = 4'b1000; idx[11:9] = 3'd0;
    tick();
    chk("r3_gnt", gnt, 4'b1000);
    chk("r3_q", q, q_exp);
    req = 4'b0000;

    // Contention: all four request, each targeting its own flag
    req = 4'b1111; s = 4'b1111; idx = {3'd3, 3'd2, 3'd1, 3'd0};
    for (int c = 0; c < 4; c++) begin
      tick();
`ifdef SR_ARB_RR_EN
      g_exp = 4'b0001 << c;
      q_exp = q_exp | (8'h01 << c);
`else
      g_exp = 4'b0001;
      q_exp = q_exp | 8'h01;
`endif
      chk("cont_gnt", gnt, g_exp);
      chk("cont_q", q, q_exp);
    end
    req = 4'b0000; s = 4'b0000;
    tick();
    chk("cont_idle_gnt", gnt, 4'b0000);

    // Lock: requester 1 locks and sets flag 0
    req = 4'b0010; s = 4'b0010; idx = '0; lock = 4'b0010;
    tick();
    q_exp = q_exp | 8'h01;
    chk("lk1_gnt", gnt, 4'b0010);
    chk("lk1_q", q, q_exp);
    chk("lk1_locked", locked, 1'b1);
    chk("lk1_owner", owner, 2'd1);
    // Owner sets flag 1 while requester 0 also asks (flag 4)
    req = 4'b0011; s = 4'b0011; idx[5:3] = 3'd1; idx[2:0] = 3'd4;
    tick();
    q_exp = q_exp | 8'h02;
    chk("lk2_gnt", gnt, 4'b0010);
    chk("lk2_q", q, q_exp);
    chk("lk2_locked", locked, 1'b1);
    // Owner idle but keeps lock: requester 0 still blocked
    req = 4'b0001;
    tick();
    chk("lk3_gnt", gnt, 4'b0000);
    chk("lk3_locked", locked, 1'b1);
    // Owner releases lock with no command
    lock = 4'b0000;
    tick();
    chk("lk4_gnt", gnt, 4'b0000);
    chk("lk4_locked", locked, 1'b0);
    chk("lk4_owner", owner, 2'd0);
    tick();
    q_exp = q_exp | 8'h10;
    chk("lk5_gnt", gnt, 4'b0001);
    chk("lk5_q", q, q_exp);
    req = 4'b0000; s = 4'b0000;

    // Lock released together with a final owner command; others wait a cycle
    req = 4'b0010; s = 4'b0010; lock = 4'b0010; idx = '0; idx[5:3] = 3'd2;
    tick();
    q_exp = q_exp | 8'h04;
    chk("ex1_gnt", gnt, 4'b0010);
    chk("ex1_locked", locked, 1'b1);
    req = 4'b0011; s = 4'b0011; lock = 4'b0000; idx[5:3] = 3'd3; idx[2:0] = 3'd5;
    tick();
    q_exp = q_exp | 8'h08;
    chk("ex2_gnt", gnt, 4'b0010);
    chk("ex2_locked", locked, 1'b0);
    chk("ex2_q", q, q_exp);
    req = 4'b0001;
    tick();
    q_exp = q_exp | 8'h20;
    chk("ex3_gnt", gnt, 4'b0001);
    chk("ex3_q", q, q_exp);
    req = 4'b0000; s = 4'b0000;
    chk("main_err", err, 1'b0);

    // Out-of-range index on the NFLAG=6 instance
    req6 = 4'b0001; s6 = 4'b0001; idx6[2:0] = 3'd7;
    tick();
    chk("oor_gnt", gnt6, 4'b0001);
    chk("oor_q", q6, 6'h00);
    chk("oor_err", err6, 1'b1);
    idx6[2:0] = 3'd2;
    tick();
    chk("oor2_q", q6, 6'h04);
    chk("oor2_err", err6, 1'b1);
    req6 = 4'b0000; s6 = 4'b0000;
    tick();
    tick();
    chk("oor_sticky", err6, 1'b1);

    // Fill all flags under a lock from requester 2, then reset mid-lock
    req = 4'b0100; s = 4'b0100; lock = 4'b0100;
    for (int f = 0; f < 8; f++) begin
      idx[8:6] = 3'(f);
      tick();
    end
    chk("fill_q", q, 8'hFF);
    chk("fill_locked", locked, 1'b1);
    chk("fill_owner", owner, 2'd2);
    chk("fill_gnt", gnt, 4'b0100);
    rst = 1'b1;
    #1;
    chk("arst_q", q, 8'h00);
    chk("arst_gnt", gnt, 4'b0000);
    chk("arst_locked", locked, 1'b0);
    chk("arst_owner", owner, 2'd0);
    chk("arst_err6", err6, 1'b0);
    chk("arst_q6", q6, 6'h00);
    req = 4'b0000; s = 4'b0000; lock = 4'b0000;
    tick();
    rst = 1'b0;
    tick();
    chk("post_gnt", gnt, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
